// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word type, condition codes, pc_src encodings,
// instruction field positions and the fetch FSM state type.
package cpu_pkg;

  typedef logic [15:0] word_t;

  // Fetch FSM states; the encoding is also driven out on dbg_state.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } fetch_state_e;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_LO = 4'b1010;
  localparam logic [3:0] COND_HS = 4'b1011;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;

  localparam logic [1:0] PC_SRC_INC  = 2'b00;
  localparam logic [1:0] PC_SRC_REG  = 2'b01;
  localparam logic [1:0] PC_SRC_REL  = 2'b10;
  localparam logic [1:0] PC_SRC_HOLD = 2'b11;

  localparam int OP_HI     = 15;
  localparam int OP_LO     = 12;
  localparam int RDEST_HI  = 11;
  localparam int RDEST_LO  = 8;
  localparam int OPEXT_HI  = 7;
  localparam int OPEXT_LO  = 4;
  localparam int RSRC_HI   = 3;
  localparam int RSRC_LO   = 0;
  localparam int IMM8_HI   = 7;
  localparam int IMM8_LO   = 0;

  // PSR bit positions inside flags {N,Z,F,L,C}.
  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_C = 0;

  function automatic word_t sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator. Full PSR decode when FETCH_COND_EVAL_EN is
// defined; otherwise only the unconditional code is true and flags is ignored.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       cond_true
);

`ifdef FETCH_COND_EVAL_EN
  logic w_n, w_z, w_f, w_l, w_c;
  assign w_n = flags[FLAG_N];
  assign w_z = flags[FLAG_Z];
  assign w_f = flags[FLAG_F];
  assign w_l = flags[FLAG_L];
  assign w_c = flags[FLAG_C];

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true = w_z;
      COND_NE: cond_true = !w_z;
      COND_CS: cond_true = w_c;
      COND_CC: cond_true = !w_c;
      COND_HI: cond_true = w_l;
      COND_LS: cond_true = !w_l;
      COND_GT: cond_true = w_n;
      COND_LE: cond_true = !w_n;
      COND_FS: cond_true = w_f;
      COND_FC: cond_true = !w_f;
      COND_LO: cond_true = !w_l && !w_z;
      COND_HS: cond_true = w_l || w_z;
      COND_LT: cond_true = !w_n && !w_z;
      COND_GE: cond_true = w_n || w_z;
      COND_UC: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end
`else
  logic w_unused_flags;
  assign w_unused_flags = ^flags;
  assign cond_true      = (cond == COND_UC);
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, next-PC select and a 4-state fetch FSM.
// Condition evaluation depth is selected by FETCH_COND_EVAL_EN (see cond_eval).
module fetch_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_en,
  input  logic [1:0]  pc_src,
  input  logic        pc_cond,
  input  logic [15:0] reg_target,
  input  logic [4:0]  flags,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic [3:0]  op,
  output logic [3:0]  rdest,
  output logic [3:0]  op_ext,
  output logic [3:0]  rsrc,
  output logic [3:0]  cond,
  output logic [7:0]  imm8,
  output logic [15:0] pc,
  output logic [15:0] pc_plus1,
  output logic        cond_true,
  output logic        fetch_done,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Memory handshake: mem_req rises in REQ and stays high with mem_addr
  // stable until a cycle where mem_ack=1; that cycle's mem_rdata is the
  // instruction. mem_ack outside REQ/WAIT carries no meaning and is dropped.

  fetch_state_e r_state;
  word_t        r_pc;
  word_t        r_instr;
  logic         r_mem_req;
  logic         r_fetch_done;
  logic         r_busy;

  word_t        w_pc_plus1;
  word_t        w_pc_rel;
  word_t        w_pc_next;
  logic         w_cond_true;

  assign w_pc_plus1 = r_pc + 16'd1;
  assign w_pc_rel   = r_pc + sext8(r_instr[IMM8_HI:IMM8_LO]);

  // A failed condition on a register or relative jump falls through to pc+1.
  always_comb begin
    w_pc_next = w_pc_plus1;
    case (pc_src)
      PC_SRC_INC:  w_pc_next = w_pc_plus1;
      PC_SRC_REG:  w_pc_next = (pc_cond && !w_cond_true) ? w_pc_plus1 : reg_target;
      PC_SRC_REL:  w_pc_next = (pc_cond && !w_cond_true) ? w_pc_plus1 : w_pc_rel;
      PC_SRC_HOLD: w_pc_next = r_pc;
      default:     w_pc_next = r_pc;
    endcase
  end

  cond_eval u_cond_eval (
    .cond      (r_instr[RDEST_HI:RDEST_LO]),
    .flags     (flags),
    .cond_true (w_cond_true)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pc         <= 16'h0000;
      r_instr      <= 16'h0000;
      r_mem_req    <= 1'b0;
      r_fetch_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_fetch_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (pc_en) r_pc <= w_pc_next;
          if (fetch_start) begin
            r_state   <= S_REQ;
            r_mem_req <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_REQ, S_WAIT: begin
          if (mem_ack) begin
            r_instr      <= mem_rdata;
            r_state      <= S_DONE;
            r_mem_req    <= 1'b0;
            r_fetch_done <= 1'b1;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr   = r_pc;
  assign mem_req    = r_mem_req;
  assign instr      = r_instr;
  assign op         = r_instr[OP_HI:OP_LO];
  assign rdest      = r_instr[RDEST_HI:RDEST_LO];
  assign op_ext     = r_instr[OPEXT_HI:OPEXT_LO];
  assign rsrc       = r_instr[RSRC_HI:RSRC_LO];
  assign cond       = r_instr[RDEST_HI:RDEST_LO];
  assign imm8       = r_instr[IMM8_HI:IMM8_LO];
  assign pc         = r_pc;
  assign pc_plus1   = w_pc_plus1;
  assign cond_true  = w_cond_true;
  assign fetch_done = r_fetch_done;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: condition table plus hand-written fetch,
// PC-update and reset sequences. Expectations follow FETCH_COND_EVAL_EN.
module tb_fetch_unit;

`ifdef FETCH_COND_EVAL_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_start;
  logic        pc_en;
  logic [1:0]  pc_src;
  logic        pc_cond;
  logic [15:0] reg_target;
  logic [4:0]  flags;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic [3:0]  op, rdest, op_ext, rsrc, cond;
  logic [7:0]  imm8;
  logic [15:0] pc, pc_plus1;
  logic        cond_true, fetch_done, busy;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_pc;

  typedef struct {
    logic [15:0] rdata;
    logic [4:0]  flags;
    logic        ct_en;
    logic        ct_dis;
  } vec_t;
  vec_t vecs[17];

  fetch_unit dut (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_en(pc_en),
    .pc_src(pc_src), .pc_cond(pc_cond), .reg_target(reg_target), .flags(flags),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .op(op), .rdest(rdest), .op_ext(op_ext), .rsrc(rsrc),
    .cond(cond), .imm8(imm8), .pc(pc), .pc_plus1(pc_plus1), .cond_true(cond_true),
    .fetch_done(fetch_done), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full fetch from IDLE with a given number of memory wait cycles.
  task automatic do_fetch(input logic [15:0] data, input int waits);
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("req_mem_req", {15'd0, mem_req}, 16'd1);
    chk("req_addr", mem_addr, exp_pc);
    chk("req_busy", {15'd0, busy}, 16'd1);
    for (int w = 0; w < waits; w++) begin
      mem_ack = 1'b0;
      step();
      chk("wait_mem_req", {15'd0, mem_req}, 16'd1);
      chk("wait_addr", mem_addr, exp_pc);
      chk("wait_no_done", {15'd0, fetch_done}, 16'd0);
    end
    mem_ack   = 1'b1;
    mem_rdata = data;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    chk("done_pulse", {15'd0, fetch_done}, 16'd1);
    chk("done_instr", instr, data);
    chk("done_mem_req", {15'd0, mem_req}, 16'd0);
    step();
    chk("idle_done_low", {15'd0, fetch_done}, 16'd0);
    chk("idle_busy", {15'd0, busy}, 16'd0);
  endtask

  task automatic set_pc(input logic [1:0] src, input logic cnd, input logic [15:0] tgt,
                        input logic [15:0] exp);
    pc_en = 1'b1; pc_src = src; pc_cond = cnd; reg_target = tgt;
    step();
    pc_en = 1'b0; pc_cond = 1'b0;
    exp_pc = exp;
    chk("pc_update", pc, exp);
  endtask

  initial begin
    vecs[0]  = '{16'h5A21, 5'b00000, 1'b1, 1'b0}; // LO, !L&!Z
    vecs[1]  = '{16'h0000, 5'b01000, 1'b1, 1'b0}; // EQ, Z
    vecs[2]  = '{16'h0100, 5'b01000, 1'b0, 1'b0}; // NE, Z
    vecs[3]  = '{16'h0200, 5'b00001, 1'b1, 1'b0}; // CS, C
    vecs[4]  = '{16'h0300, 5'b00001, 1'b0, 1'b0}; // CC, C
    vecs[5]  = '{16'h0400, 5'b00010, 1'b1, 1'b0}; // HI, L
    vecs[6]  = '{16'h0500, 5'b00000, 1'b1, 1'b0}; // LS, none
    vecs[7]  = '{16'h0600, 5'b10000, 1'b1, 1'b0}; // GT, N
    vecs[8]  = '{16'h0700, 5'b10000, 1'b0, 1'b0}; // LE, N
    vecs[9]  = '{16'h0800, 5'b00100, 1'b1, 1'b0}; // FS, F
    vecs[10] = '{16'h0900, 5'b00000, 1'b1, 1'b0}; // FC, none
    vecs[11] = '{16'h0B00, 5'b00000, 1'b0, 1'b0}; // HS, none
    vecs[12] = '{16'h0C00, 5'b00000, 1'b1, 1'b0}; // LT, none
    vecs[13] = '{16'h0D00, 5'b01000, 1'b1, 1'b0}; // GE, Z
    vecs[14] = '{16'h0E00, 5'b00000, 1'b1, 1'b1}; // UC
    vecs[15] = '{16'h0F00, 5'b11111, 1'b0, 1'b0}; // never
    vecs[16] = '{16'h0A00, 5'b00010, 1'b0, 1'b0}; // LO, L

    reset = 1'b0; fetch_start = 1'b0; pc_en = 1'b0; pc_src = 2'b00; pc_cond = 1'b0;
    reg_target = 16'h0000; flags = 5'b00000; mem_ack = 1'b0; mem_rdata = 16'h0000;
    exp_pc = 16'h0000;
    step(); step();
    reset = 1'b1;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_mem_req", {15'd0, mem_req}, 16'd0);
    chk("rst_done", {15'd0, fetch_done}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_state", {14'd0, dbg_state}, 16'd0);
    chk("rst_pc_plus1", pc_plus1, 16'h0001);

    // Minimum-latency fetch and field decode
    do_fetch(16'h5A21, 0);
    chk("op", {12'd0, op}, 16'h0005);
    chk("rdest", {12'd0, rdest}, 16'h000A);
    chk("op_ext", {12'd0, op_ext}, 16'h0002);
    chk("rsrc", {12'd0, rsrc}, 16'h0001);
    chk("cond", {12'd0, cond}, 16'h000A);
    chk("imm8", {8'd0, imm8}, 16'h0021);

    // Three memory wait cycles
    do_fetch(16'hC3B4, 3);

    // Condition table
    for (int i = 0; i < 17; i++) begin
      flags = vecs[i].flags;
      do_fetch(vecs[i].rdata, i % 2);
      chk($sformatf("cond_true_v%0d", i), {15'd0, cond_true},
          {15'd0, COND_EN ? vecs[i].ct_en : vecs[i].ct_dis});
    end
    flags = 5'b00000;

    // PC arithmetic: absolute, relative negative, wrap, hold
    set_pc(2'b01, 1'b0, 16'h0010, 16'h0010);
    do_fetch(16'h00FE, 0);
    set_pc(2'b10, 1'b0, 16'h0000, 16'h000E);
    set_pc(2'b01, 1'b0, 16'hFFFF, 16'hFFFF);
    chk("pc_plus1_wrap", pc_plus1, 16'h0000);
    set_pc(2'b00, 1'b0, 16'h0000, 16'h0000);
    set_pc(2'b11, 1'b0, 16'h5555, 16'h0000);

    // Conditional register jump on EQ
    do_fetch(16'h0000, 0);
    set_pc(2'b01, 1'b0, 16'h0020, 16'h0020);
    flags = 5'b00000;
    set_pc(2'b01, 1'b1, 16'h1234, 16'h0021);
    flags = 5'b01000;
    set_pc(2'b01, 1'b1, 16'h1234, COND_EN ? 16'h1234 : 16'h0022);
    flags = 5'b00000;

    // pc_en and fetch_start while busy are ignored
    fetch_start = 1'b1;
    step();
    pc_en = 1'b1; pc_src = 2'b01; reg_target = 16'h7777;
    step();
    pc_en = 1'b0; fetch_start = 1'b0;
    chk("busy_addr_stable", mem_addr, exp_pc);
    chk("busy_state_wait", {14'd0, dbg_state}, 16'd2);
    mem_ack = 1'b1; mem_rdata = 16'h1E00;
    step();
    mem_ack = 1'b0; fetch_start = 1'b1;
    chk("busy_done", {15'd0, fetch_done}, 16'd1);
    step();
    fetch_start = 1'b0;
    chk("no_queue_mem_req", {15'd0, mem_req}, 16'd0);
    chk("no_queue_busy", {15'd0, busy}, 16'd0);
    step();
    chk("no_queue_mem_req2", {15'd0, mem_req}, 16'd0);
    chk("busy_pc_unchanged", pc, exp_pc);

    // Simultaneous pc_en and fetch_start: fetch uses the updated pc
    pc_en = 1'b1; pc_src = 2'b00; fetch_start = 1'b1;
    step();
    pc_en = 1'b0; fetch_start = 1'b0;
    exp_pc = exp_pc + 16'd1;
    chk("sim_pc", pc, exp_pc);
    chk("sim_addr", mem_addr, exp_pc);
    chk("sim_mem_req", {15'd0, mem_req}, 16'd1);
    mem_ack = 1'b1; mem_rdata = 16'h3C55;
    step();
    mem_ack = 1'b0;
    chk("sim_done", {15'd0, fetch_done}, 16'd1);
    step();

    // Stray mem_ack in IDLE
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_instr", instr, 16'h3C55);
    chk("idle_ack_done", {15'd0, fetch_done}, 16'd0);
    chk("idle_ack_busy", {15'd0, busy}, 16'd0);

    // Reset during WAIT aborts the fetch
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    step();
    chk("pre_rst_wait", {14'd0, dbg_state}, 16'd2);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hAAAA;
    step();
    reset = 1'b1; mem_ack = 1'b0;
    chk("abort_mem_req", {15'd0, mem_req}, 16'd0);
    chk("abort_pc", pc, 16'h0000);
    chk("abort_instr", instr, 16'h0000);
    chk("abort_done", {15'd0, fetch_done}, 16'd0);
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_state", {14'd0, dbg_state}, 16'd0);
    step();
    chk("abort_done2", {15'd0, fetch_done}, 16'd0);
    chk("abort_mem_req2", {15'd0, mem_req}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-low; clock clk.
REQ-003 fetch_start  in  1  one-cycle fetch request, driven from controller instrWrite.
REQ-004 pc_en  in  1  PC update strobe from controller.
REQ-005 pc_src  in  2  next-PC select: 00 pc+1, 01 reg_target, 10 pc+sext(imm8), 11 hold.
REQ-006 pc_cond  in  1  gate the pc_src 01/10 update with cond_true; a failed condition selects pc+1.
REQ-007 reg_target  in  16  absolute jump target from the register file (Rtarget).
REQ-008 flags  in  5  PSR {N,Z,F,L,C}, bit 4 = N.
REQ-009 mem_addr  out  16  instruction address, equals pc while mem_req=1.
REQ-010 mem_req  out  1  instruction read request.
REQ-011 mem_ack  in  1  read data valid this cycle.
REQ-012 mem_rdata  in  16  instruction word.
REQ-013 instr  out  16  instruction register.
REQ-014 op, rdest, op_ext, rsrc  out  4 each  instr[15:12], [11:8], [7:4], [3:0].
REQ-015 cond  out  4  equals rdest (Bcond/Jcond condition field).
REQ-016 imm8  out  8  instr[7:0].
REQ-017 pc  out  16  current PC.
REQ-018 pc_plus1  out  16  pc+1, modulo 2^16; this is the JAL link value.
REQ-019 cond_true  out  1  combinational evaluation of cond against flags.
REQ-020 fetch_done  out  1  one-cycle pulse when instr is updated.
REQ-021 busy  out  1  high in any state other than IDLE.

Function
REQ-022 FSM states: IDLE, REQ, WAIT, DONE; exactly one state is active.
REQ-023 IDLE: fetch_start=1 -> REQ; otherwise stay in IDLE.
REQ-024 REQ: mem_req=1, mem_addr=pc; mem_ack=1 -> DONE and instr<=mem_rdata; otherwise -> WAIT.
REQ-025 WAIT: mem_req held at 1 with mem_addr stable; mem_ack=1 -> DONE and instr<=mem_rdata; no timeout.
REQ-026 DONE: fetch_done=1 for one cycle, then -> IDLE.
REQ-027 Minimum latency: fetch_start at cycle t gives fetch_done at cycle t+2 when mem_ack arrives in REQ.
REQ-028 Each additional wait cycle of memory adds one cycle to that latency.
REQ-029 pc updates only when pc_en=1 and state=IDLE; a pc_en in any other state is ignored.
REQ-030 Simultaneous pc_en and fetch_start in IDLE: the PC update happens first, and the fetch uses the new pc one cycle later.
REQ-031 fetch_start while busy=1 is ignored and is not queued.
REQ-032 mem_ack received in IDLE or DONE is ignored.
REQ-033 Relative target = pc + sign-extended imm8, modulo 2^16.
REQ-034 pc+1 wraps from 0xFFFF to 0x0000.
REQ-035 cond_true is defined by the condition code as follows.
  - EQ 0000: Z
  - NE 0001: !Z
  - CS 0010: C
  - CC 0011: !C
  - HI 0100: L
  - LS 0101: !L
  - GT 0110: N
  - LE 0111: !N
  - FS 1000: F
  - FC 1001: !F
  - LO 1010: !L&!Z
  - HS 1011: L|Z
  - LT 1100: !N&!Z
  - GE 1101: N|Z
  - UC 1110: 1
  - 1111: 0

Reset
REQ-036 reset=0 at a clock edge sets state=IDLE, pc=0x0000, instr=0x0000, mem_req=0, fetch_done=0, busy=0.
REQ-037 Reset asserted mid-fetch aborts the fetch: mem_req=0 from the next cycle and instr is not loaded.

Configuration
REQ-038 Macro FETCH_COND_EVAL_EN defined: cond_true follows REQ-035.
REQ-039 Macro FETCH_COND_EVAL_EN undefined: cond_true=1 for cond=1110, otherwise 0; flags is unused.

Structure
REQ-040 Shared package cpu_pkg holds the following definitions.
  - Condition-code constants EQ..UC.
  - pc_src encodings.
  - Instruction field bit positions.
  - The 16-bit word type.
REQ-041 Sub-module cond_eval (cond, flags -> cond_true) SHALL be instantiated once; the macro selects its body.

Verification
REQ-042 Reset, then fetch_start with mem_ack in REQ and mem_rdata=0x5A21 -> fetch_done 2 cycles later, op=5, rdest=A, op_ext=2, rsrc=1.
REQ-043 fetch_start with mem_ack delayed 3 cycles -> mem_addr stable for 4 cycles, fetch_done at t+5.
REQ-044 pc=0x0010, pc_src=10, imm8=0xFE, pc_en -> pc=0x000E; pc=0xFFFF, pc_src=00 -> pc=0x0000.
REQ-045 pc_cond=1, pc_src=01, reg_target=0x1234, cond=EQ:
  - Z=0 -> pc=pc+1.
  - Z=1 -> pc=0x1234.
  - With FETCH_COND_EVAL_EN undefined -> pc=pc+1 in both cases.
REQ-046 Reset pulled low while in WAIT -> next cycle: state IDLE, mem_req=0, pc=0, instr=0, no fetch_done.
